// File: rtl/seq_array_mult_pkg.sv
// Shared definitions for the sequential add-and-shift multiplier:
// FSM state enumeration and counter sizing helper.
package seq_array_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must hold 0..w, hence clog2(w+1) bits.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_array_mult_step.sv
// One RUN cycle of the multiplier: conditionally add the multiplicand
// magnitude into the accumulator upper half, then shift right by one.
module mult_addshift_step #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   mcand,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
      if (acc_in[0])
         sum = sum + {1'b0, mcand};
      // Carry out of the add becomes the new MSB after the shift.
      acc_out = {sum, acc_in[WIDTH-1:1]};
   end

endmodule

// File: rtl/seq_array_mult.sv
// Sequential shift-and-add multiplier with optional two's complement mode;
// WIDTH RUN cycles per product, result registered on the RUN->DONE edge.
module seq_array_mult
   import seq_array_mult_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          SIGNED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               sgn,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p,
   output logic               busy,
   output logic               done
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t             state, state_nx;
   logic [2*WIDTH-1:0] acc, acc_step;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [CW-1:0]      cnt;
   logic               neg, eff_sgn, load, last;

   // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
   always_comb begin
      eff_sgn = SIGNED_EN && sgn;
      a_mag   = (eff_sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag   = (eff_sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      last    = (cnt == CW'(WIDTH - 1));
   end

   mult_addshift_step #(.WIDTH(WIDTH)) u_step (
      .acc_in  (acc),
      .mcand   (mcand),
      .acc_out (acc_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last)
               state_nx = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               load     = 1'b1;
               state_nx = ST_RUN;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Multiplier magnitude rides in the accumulator low half and shifts out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         mcand <= '0;
         neg   <= 1'b0;
         cnt   <= '0;
         p     <= '0;
      end else if (load) begin
         acc   <= {{WIDTH{1'b0}}, b_mag};
         mcand <= a_mag;
         neg   <= eff_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
         cnt   <= '0;
      end else if (state == ST_RUN) begin
         acc <= acc_step;
         cnt <= cnt + CW'(1);
         if (last)
            p <= neg ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
      end
   end

endmodule

// File: tb/tb_seq_array_mult.sv
// Self-checking bench for seq_array_mult (WIDTH=4): directed vectors plus a
// cycle-level protocol model compared against the DUT on every clock.
module tb_seq_array_mult;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           sgn = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [2*W-1:0] p;
   logic           busy;
   logic           done;

   int n_checks = 0;
   int n_fail   = 0;

   seq_array_mult #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sgn   (sgn),
      .a     (a),
      .b     (b),
      .p     (p),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Reference product from plain integer arithmetic.
   function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s);
      int ix, iy, r;
      ix = int'(x);
      iy = int'(y);
      if (s) begin
         if (x[W-1]) ix = ix - (1 << W);
         if (y[W-1]) iy = iy - (1 << W);
      end
      r = ix * iy;
      return r[2*W-1:0];
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Protocol model: a multiply accepted when idle completes W edges later.
   int             m_rem  = 0;
   logic [2*W-1:0] m_p    = '0;
   logic [2*W-1:0] m_pend = '0;
   logic           m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_p    <= '0;
         m_done <= 1'b0;
      end else begin
         m_done <= (m_rem == 1);
         if (m_rem == 1) m_p <= m_pend;
         if (m_rem > 0) m_rem <= m_rem - 1;
         else if (start) begin
            m_rem  <= W;
            m_pend <= ref_mult(a, b, sgn);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_p",    16'(p),    16'(m_p));
         chk("cyc_busy", 16'(busy), 16'(m_rem != 0));
         chk("cyc_done", 16'(done), 16'(m_done));
      end
   end

   task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input logic [2*W-1:0] exp, input string name);
      int n;
      bit seen;
      @(negedge clk);
      a = x; b = y; sgn = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk({name, "_lat"}, 16'(seen ? n : 0), 16'(W + 1));
      chk({name, "_p"}, 16'(p), 16'(exp));
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 20 && !done; i++) @(negedge clk);
      chk(name, 16'(done), 16'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_p",    16'(p),    16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      rst_n = 1'b1;

      // Pin the reference model to hand-computed values.
      chk("ref_11x10", 16'(ref_mult(4'd11, 4'd10, 1'b0)), 16'd110);
      chk("ref_15x15", 16'(ref_mult(4'd15, 4'd15, 1'b0)), 16'd225);
      chk("ref_m1xm1", 16'(ref_mult(4'hF, 4'hF, 1'b1)),   16'd1);
      chk("ref_m8xm8", 16'(ref_mult(4'h8, 4'h8, 1'b1)),   16'd64);
      chk("ref_m8x7",  16'(ref_mult(4'h8, 4'h7, 1'b1)),   16'hC8);

      run(4'd11, 4'd10, 1'b0, 8'd110,  "u_11x10");
      run(4'd15, 4'd15, 1'b0, 8'd225,  "u_15x15");
      run(4'hF,  4'hF,  1'b1, 8'd1,    "s_m1xm1");
      run(4'h8,  4'h8,  1'b1, 8'd64,   "s_m8xm8");
      run(4'h8,  4'h7,  1'b1, 8'hC8,   "s_m8x7");
      run(4'd8,  4'd0,  1'b0, 8'd0,    "zero");
      run(4'd1,  4'd12, 1'b0, 8'd12,   "ident");

      // start re-pulsed mid-RUN with different operands is ignored
      @(negedge clk);
      a = 4'd5; b = 4'd6; sgn = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'd3; b = 4'd11; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = '0; b = '0;
      wait_done("ign_done");
      chk("ign_p", 16'(p), 16'd30);

      // start held through DONE: second multiply begins with no IDLE cycle
      @(negedge clk);
      a = 4'd2; b = 4'd7; start = 1'b1;
      @(negedge clk);
      a = 4'd3; b = 4'd11;
      wait_done("b2b_done1");
      chk("b2b_p1", 16'(p), 16'd14);
      @(negedge clk);
      chk("b2b_busy", 16'(busy), 16'd1);
      chk("b2b_nodone", 16'(done), 16'd0);
      start = 1'b0;
      wait_done("b2b_done2");
      chk("b2b_p2", 16'(p), 16'd33);

      // reset asserted during RUN aborts the operation
      @(negedge clk);
      a = 4'd9; b = 4'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_p",    16'(p),    16'd0);
      chk("abort_busy", 16'(busy), 16'd0);
      chk("abort_done", 16'(done), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         chk("abort_nodone", 16'(done), 16'd0);
      end
      run(4'd7, 4'd9, 1'b0, 8'd63, "post_rst");

      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
               run(4'(i), 4'(j), 1'(s), ref_mult(4'(i), 4'(j), 1'(s)), "sweep");

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
